// File: rtl/cell_pos_streamer.sv
// Read-side sequencer for one cell position memory: fetches the particle count, then
// streams every record through a credit-controlled FIFO. CELL_POS_STREAMER_STALL_CNT_EN adds stall_cycles.
module cell_pos_streamer #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  out_last,
    output logic [ADDR_WIDTH-1:0] cell_count,
    output logic                  count_err
`ifdef CELL_POS_STREAMER_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic                  wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic                  err_q, err_d;
    logic                  s1_valid_q, s2_valid_q, s1_last_q, s2_last_q;
    logic [ADDR_WIDTH-1:0] s1_pid_q, s2_pid_q;

    logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic [EW-1:0]         head;
    logic                  fifo_empty, fifo_full, push, pop, issue, drained;
    logic [CW:0]           outstanding;
    logic [ADDR_WIDTH-1:0] raw_count, clamped_count;
    logic                  raw_over;

    assign fifo_empty  = (fifo_cnt_q == '0);
    assign fifo_full   = (fifo_cnt_q == CW'(FIFO_DEPTH));
    assign pop         = out_valid && out_ready;
    assign push        = s2_valid_q;
    // Credit: a read may only launch if its record is guaranteed a FIFO slot on arrival.
    assign outstanding = {1'b0, fifo_cnt_q} + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q);
    assign issue       = (state_q == STREAM) && (outstanding < (CW+1)'(FIFO_DEPTH));
    // Looks ahead through the final pop so done lands one cycle after the last beat.
    assign drained     = !s1_valid_q && !s2_valid_q &&
                         (fifo_empty || ((fifo_cnt_q == CW'(1)) && pop));

    assign raw_count     = rd_q[ADDR_WIDTH-1:0];
    assign raw_over      = (raw_count > MAX_COUNT);
    assign clamped_count = raw_over ? MAX_COUNT : raw_count;

    assign head       = fifo_mem[rd_ptr_q];
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? '0 : head[EW-1 -: DATA_WIDTH];
    assign out_pid    = fifo_empty ? '0 : head[ADDR_WIDTH:1];
    assign out_last   = !fifo_empty && head[0];
    assign rd_en      = (state_q == RD_CNT) || issue;
    assign rd_addr    = (state_q == STREAM) ? addr_q : '0;
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign done       = (state_q == DONE);
    assign cell_count = count_q;
    assign count_err  = err_q;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_CNT;
                    err_d   = 1'b0;
                end
            end
            RD_CNT: begin
                state_d = WAIT_CNT;
                wait_d  = 1'b0;
            end
            WAIT_CNT: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    count_d = clamped_count;
                    err_d   = raw_over;
                    addr_d  = ADDR_WIDTH'(1);
                    state_d = (clamped_count == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == count_q) state_d = DRAIN;
                end
            end
            DRAIN:   if (drained) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_q     <= 1'b0;
            addr_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_last_q  <= 1'b0;
            s1_pid_q   <= '0;
            s2_pid_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            s1_valid_q <= issue;
            s1_pid_q   <= addr_q;
            s1_last_q  <= (addr_q == count_q);
            s2_valid_q <= s1_valid_q;
            s2_pid_q   <= s1_pid_q;
            s2_last_q  <= s1_last_q;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Payload storage carries no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q] <= {rd_q, s2_pid_q, s2_last_q};
    end

`ifdef CELL_POS_STREAMER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start)
            stall_d = '0;
        else if (busy && out_valid && !out_ready && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

`ifndef SYNTHESIS
    fifo_no_overflow: assert property (@(posedge clock) disable iff (!rst_n)
        !(push && fifo_full && !pop));
`endif
endmodule

// File: tb/tb_cell_pos_streamer.sv
// Self-checking bench for cell_pos_streamer: RAM model with 2-cycle read latency,
// stream monitor, and a reference model of the expected record sequence per cell.
module tb_cell_pos_streamer;
    localparam int DW   = 96;
    localparam int AW   = 8;
    localparam int PN   = 220;
    localparam int FD   = 4;
    localparam int MAXC = PN - 1;

    logic          clock     = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, rd_en, out_valid, out_last, count_err;
    logic [AW-1:0] rd_addr, out_pid, cell_count;
    logic [DW-1:0] rd_q = '0;
    logic [DW-1:0] out_data;
`ifdef CELL_POS_STREAMER_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    logic [DW-1:0] mem [PN];
    logic [DW-1:0] q1 = '0;

    int passed = 0, total = 0, cyc = 0, ready_mode = 0, ready_phase = 0, start_cyc = 0;
    int addr_log[$];
    int got_pid[$];
    logic [DW-1:0] got_data[$];
    bit got_last[$];
    int got_cyc[$];
    int done_cnt = 0, done_cyc = 0, first_valid_cyc = -1;
    int issued = 0, accepted = 0, max_out = 0, stall_obs = 0, stab_err = 0;
    bit held_v = 1'b0;
    logic [AW-1:0] held_pid;
    logic [DW-1:0] held_data;
    logic held_last;

    cell_pos_streamer dut (
        .clock(clock), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_q(rd_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pid(out_pid), .out_last(out_last),
        .cell_count(cell_count), .count_err(count_err)
`ifdef CELL_POS_STREAMER_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    always @(posedge clock) begin
        if (rd_en && (int'(rd_addr) < PN)) q1 <= mem[rd_addr];
        rd_q <= q1;
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (ready_phase % 3 == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            ready_phase++;
        end
    end

    always @(negedge clock) begin
        if (rst_n) begin
            if (rd_en) begin
                addr_log.push_back(int'(rd_addr));
                if (rd_addr != 0) begin
                    issued++;
                    if (issued - accepted > max_out) max_out = issued - accepted;
                end
            end
            if (out_valid && out_ready) begin
                got_pid.push_back(int'(out_pid));
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                got_cyc.push_back(cyc);
                accepted++;
            end
            if (out_valid && !out_ready && busy) stall_obs++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (held_v && (!out_valid || out_pid !== held_pid || out_data !== held_data || out_last !== held_last))
                stab_err++;
            held_v    = out_valid && !out_ready;
            held_pid  = out_pid;
            held_data = out_data;
            held_last = out_last;
        end else begin
            held_v = 1'b0;
        end
    end

    function automatic int model_count(input int raw);
        return (raw > MAXC) ? MAXC : raw;
    endfunction

    task automatic fill_cell(input int raw);
        mem[0] = {$urandom, $urandom, 24'($urandom), 8'(raw)};
        for (int i = 1; i < PN; i++) mem[i] = {$urandom, $urandom, $urandom};
    endtask

    task automatic clear_logs();
        addr_log.delete(); got_pid.delete(); got_data.delete(); got_last.delete(); got_cyc.delete();
        done_cnt = 0; done_cyc = 0; first_valid_cyc = -1;
        issued = 0; accepted = 0; max_out = 0; stall_obs = 0; stab_err = 0;
    endtask

    task automatic pulse_start();
        @(posedge clock); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock); #1;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clock); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0)
            $display("FAIL reset_ctrl: busy=%b done=%b rd_en=%b required 0 0 0", busy, done, rd_en);
        else passed++;
        total++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_pid !== '0 || out_data !== '0)
            $display("FAIL reset_out: valid=%b last=%b pid=%0d data=%h required all 0", out_valid, out_last, out_pid, out_data);
        else passed++;
        total++;
        if (cell_count !== '0 || count_err !== 1'b0 || rd_addr !== '0)
            $display("FAIL reset_status: cell_count=%0d count_err=%b rd_addr=%0d required 0", cell_count, count_err, rd_addr);
        else passed++;
`ifdef CELL_POS_STREAMER_STALL_CNT_EN
        total++;
        if (stall_cycles !== 16'd0) $display("FAIL reset_stall: got %0d required 0", stall_cycles);
        else passed++;
`endif
        @(posedge clock); #1;
        rst_n = 1'b1;
        $display("run reset: released at cycle %0d", cyc);
    endtask

    task automatic test_count5();
        bit ok;
        int last_cyc;
        fill_cell(5);
        ready_mode = 0;
        clear_logs();
        pulse_start();
        wait_done(100, ok);
        total++; if (!ok) $display("FAIL count5_done: no done pulse within budget"); else passed++;
        total++;
        if (addr_log.size() != 6) $display("FAIL count5_nreads: got %0d required 6", addr_log.size());
        else passed++;
        for (int i = 0; i < addr_log.size() && i < 6; i++) begin
            total++;
            if (addr_log[i] != i) $display("FAIL count5_addr[%0d]: got %0d required %0d", i, addr_log[i], i);
            else passed++;
        end
        total++;
        if (got_pid.size() != 5) $display("FAIL count5_nbeats: got %0d required 5", got_pid.size());
        else passed++;
        for (int i = 0; i < got_pid.size(); i++) begin
            total++;
            if (got_pid[i] != i + 1 || got_data[i] !== mem[i + 1] || got_last[i] != (i + 1 == 5))
                $display("FAIL count5_beat[%0d]: pid=%0d last=%0d required pid=%0d last=%0d", i, got_pid[i], got_last[i], i + 1, (i + 1 == 5));
            else passed++;
            if (i > 0) begin
                total++;
                if (got_cyc[i] != got_cyc[i - 1] + 1)
                    $display("FAIL count5_b2b[%0d]: gap got %0d required 1", i, got_cyc[i] - got_cyc[i - 1]);
                else passed++;
            end
        end
        total++;
        if (first_valid_cyc - start_cyc != 7)
            $display("FAIL count5_latency: got %0d required 7", first_valid_cyc - start_cyc);
        else passed++;
        last_cyc = (got_cyc.size() > 0) ? got_cyc[got_cyc.size() - 1] : -100;
        total++;
        if (done_cyc != last_cyc + 1) $display("FAIL count5_done_timing: done at %0d required %0d", done_cyc, last_cyc + 1);
        else passed++;
        total++;
        if (cell_count !== 8'd5 || count_err !== 1'b0 || busy !== 1'b0 || done_cnt != 1)
            $display("FAIL count5_status: cnt=%0d err=%b busy=%b dones=%0d required 5 0 0 1", cell_count, count_err, busy, done_cnt);
        else passed++;
        $display("run count5: count=%0d beats=%0d", cell_count, got_pid.size());
    endtask

    task automatic test_count0();
        bit ok;
        fill_cell(0);
        ready_mode = 2;
        clear_logs();
        pulse_start();
        wait_done(100, ok);
        total++; if (!ok) $display("FAIL count0_done: no done pulse within budget"); else passed++;
        total++;
        if (first_valid_cyc >= 0) $display("FAIL count0_valid: out_valid seen at %0d required never", first_valid_cyc);
        else passed++;
        total++;
        if (busy !== 1'b0 || count_err !== 1'b0 || cell_count !== '0 || done_cnt != 1)
            $display("FAIL count0_status: busy=%b err=%b cnt=%0d dones=%0d required 0 0 0 1", busy, count_err, cell_count, done_cnt);
        else passed++;
        $display("run count0: count=%0d beats=%0d", cell_count, got_pid.size());
    endtask

    task automatic test_clamp();
        bit ok;
        fill_cell(250);
        ready_mode = 2;
        clear_logs();
        pulse_start();
        wait_done(3000, ok);
        total++; if (!ok) $display("FAIL clamp_done: no done pulse within budget"); else passed++;
        total++;
        if (cell_count !== AW'(MAXC) || count_err !== 1'b1)
            $display("FAIL clamp_status: cnt=%0d err=%b required %0d 1", cell_count, count_err, MAXC);
        else passed++;
        total++;
        if (got_pid.size() != model_count(250)) $display("FAIL clamp_nbeats: got %0d required %0d", got_pid.size(), model_count(250));
        else passed++;
        for (int i = 0; i < got_pid.size(); i++) begin
            total++;
            if (got_pid[i] != i + 1 || got_data[i] !== mem[i + 1] || got_last[i] != (i + 1 == model_count(250)))
                $display("FAIL clamp_beat[%0d]: pid=%0d last=%0d required pid=%0d", i, got_pid[i], got_last[i], i + 1);
            else passed++;
        end
        total++;
        if (max_out > FD || stab_err != 0) $display("FAIL clamp_flow: max_out=%0d unstable=%0d required <=%0d 0", max_out, stab_err, FD);
        else passed++;
        $display("run clamp: count=%0d beats=%0d", cell_count, got_pid.size());
    endtask

    task automatic test_stall();
        bit ok;
        fill_cell(10);
        ready_mode = 1;
        clear_logs();
        pulse_start();
        total++;
        if (count_err !== 1'b0) $display("FAIL stall_err_clear: got %b required 0", count_err);
        else passed++;
        wait_done(500, ok);
        total++; if (!ok) $display("FAIL stall_done: no done pulse within budget"); else passed++;
        total++;
        if (got_pid.size() != 10) $display("FAIL stall_nbeats: got %0d required 10", got_pid.size());
        else passed++;
        for (int i = 0; i < got_pid.size(); i++) begin
            total++;
            if (got_pid[i] != i + 1 || got_data[i] !== mem[i + 1] || got_last[i] != (i + 1 == 10))
                $display("FAIL stall_beat[%0d]: pid=%0d last=%0d required pid=%0d", i, got_pid[i], got_last[i], i + 1);
            else passed++;
        end
        total++;
        if (stab_err != 0) $display("FAIL stall_hold: %0d unstable stalled cycles required 0", stab_err);
        else passed++;
        total++;
        if (max_out > FD || stall_obs == 0) $display("FAIL stall_credit: max_out=%0d stalls=%0d required <=%0d and >0", max_out, stall_obs, FD);
        else passed++;
`ifdef CELL_POS_STREAMER_STALL_CNT_EN
        total++;
        if (int'(stall_cycles) != stall_obs) $display("FAIL stall_count: got %0d required %0d", stall_cycles, stall_obs);
        else passed++;
`endif
        $display("run stall: count=%0d beats=%0d stalls=%0d", cell_count, got_pid.size(), stall_obs);
    endtask

    task automatic test_back_to_back();
        bit ok;
        fill_cell(8);
        ready_mode = 0;
        clear_logs();
        pulse_start();
        repeat (4) @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(200, ok);
        repeat (10) @(posedge clock);
        #1;
        total++; if (!ok) $display("FAIL b2b_done: no done pulse within budget"); else passed++;
        total++;
        if (addr_log.size() != 9) $display("FAIL b2b_nreads: got %0d required 9", addr_log.size());
        else passed++;
        for (int i = 0; i < addr_log.size() && i < 9; i++) begin
            total++;
            if (addr_log[i] != i) $display("FAIL b2b_addr[%0d]: got %0d required %0d", i, addr_log[i], i);
            else passed++;
        end
        for (int i = 0; i < got_pid.size(); i++) begin
            total++;
            if (got_pid[i] != i + 1 || got_data[i] !== mem[i + 1] || got_last[i] != (i + 1 == 8))
                $display("FAIL b2b_beat[%0d]: pid=%0d required %0d", i, got_pid[i], i + 1);
            else passed++;
        end
        total++;
        if (got_pid.size() != 8 || done_cnt != 1 || busy !== 1'b0)
            $display("FAIL b2b_status: beats=%0d dones=%0d busy=%b required 8 1 0", got_pid.size(), done_cnt, busy);
        else passed++;
        $display("run back_to_back: count=%0d beats=%0d", cell_count, got_pid.size());
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        fill_cell(8);
        ready_mode = 0;
        clear_logs();
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock); #1;
            if (got_pid.size() >= 2 && out_valid) begin
                hit = 1'b1;
                break;
            end
        end
        total++; if (!hit) $display("FAIL rstmid_reach: beat 3 never presented"); else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || rd_addr !== '0)
            $display("FAIL rstmid_ctrl: busy=%b done=%b rd_en=%b rd_addr=%0d required 0", busy, done, rd_en, rd_addr);
        else passed++;
        total++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_pid !== '0 || out_data !== '0)
            $display("FAIL rstmid_out: valid=%b pid=%0d required 0 0", out_valid, out_pid);
        else passed++;
        total++;
        if (cell_count !== '0 || count_err !== 1'b0)
            $display("FAIL rstmid_status: cnt=%0d err=%b required 0 0", cell_count, count_err);
        else passed++;
        repeat (3) @(posedge clock);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        total++;
        if (done_cnt != 0 || out_valid !== 1'b0) $display("FAIL rstmid_abort: dones=%0d valid=%b required 0 0", done_cnt, out_valid);
        else passed++;
        clear_logs();
        pulse_start();
        wait_done(200, ok);
        total++; if (!ok) $display("FAIL rstmid_restart: no done pulse within budget"); else passed++;
        total++;
        if (got_pid.size() != 8) $display("FAIL rstmid_nbeats: got %0d required 8", got_pid.size());
        else passed++;
        for (int i = 0; i < got_pid.size(); i++) begin
            total++;
            if (got_pid[i] != i + 1 || got_data[i] !== mem[i + 1] || got_last[i] != (i + 1 == 8))
                $display("FAIL rstmid_beat[%0d]: pid=%0d required %0d", i, got_pid[i], i + 1);
            else passed++;
        end
        $display("run reset_mid: count=%0d beats=%0d", cell_count, got_pid.size());
    endtask

    task automatic test_random();
        bit ok;
        int raw;
        int exp_n;
        for (int r = 0; r < 3; r++) begin
            raw = $urandom_range(1, 40);
            exp_n = model_count(raw);
            fill_cell(raw);
            ready_mode = 2;
            clear_logs();
            pulse_start();
            wait_done(600, ok);
            total++; if (!ok) $display("FAIL rand%0d_done: no done pulse within budget", r); else passed++;
            total++;
            if (got_pid.size() != exp_n || int'(cell_count) != exp_n)
                $display("FAIL rand%0d_count: beats=%0d cnt=%0d required %0d", r, got_pid.size(), cell_count, exp_n);
            else passed++;
            for (int i = 0; i < got_pid.size(); i++) begin
                total++;
                if (got_pid[i] != i + 1 || got_data[i] !== mem[i + 1] || got_last[i] != (i + 1 == exp_n))
                    $display("FAIL rand%0d_beat[%0d]: pid=%0d required %0d", r, i, got_pid[i], i + 1);
                else passed++;
            end
            total++;
            if (max_out > FD || stab_err != 0) $display("FAIL rand%0d_flow: max_out=%0d unstable=%0d", r, max_out, stab_err);
            else passed++;
            $display("run random%0d: count=%0d beats=%0d", r, cell_count, got_pid.size());
        end
    endtask

    initial begin
        test_reset();
        test_count5();
        test_count0();
        test_clamp();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
